// File: rtl/eth_rx_frame_parser_if.sv
// GMII receive bundle plus the delayed, tagged output stream of the
// RX frame parser. The slave view belongs to the parser; the master view
// belongs to whatever drives GMII and consumes the tagged stream.
interface eth_rx_frame_parser_if;
    // GMII receive side
    logic        i_rx_dv;
    logic        i_rx_er;
    logic [7:0]  i_rx_d;

    // Delayed stream with frame markers and per-frame status
    logic        o_rx_dv_d;
    logic        o_rx_er_d;
    logic [7:0]  o_rx_d_d;
    logic        o_sof;
    logic        o_eof;
    logic        o_frame_ok;
    logic        o_frame_err;
    logic [3:0]  o_err_code;
    logic [15:0] o_frame_len;

    modport master (
        output i_rx_dv, i_rx_er, i_rx_d,
        input  o_rx_dv_d, o_rx_er_d, o_rx_d_d,
        input  o_sof, o_eof, o_frame_ok, o_frame_err,
        input  o_err_code, o_frame_len
    );

    modport slave (
        input  i_rx_dv, i_rx_er, i_rx_d,
        output o_rx_dv_d, o_rx_er_d, o_rx_d_d,
        output o_sof, o_eof, o_frame_ok, o_frame_err,
        output o_err_code, o_frame_len
    );
endinterface

// File: rtl/eth_rx_frame_parser.sv
// GMII receive frame parser. Delineates preamble/SFD/data, checks FCS,
// length and rx_er, and tags a pDELAY-clock delayed copy of the GMII
// stream with start/end-of-frame markers and a per-frame status.
// pDELAY must be in 2..32: the end-of-frame status is injected one stage
// into the delay line, so at least two stages are needed.
module eth_rx_frame_parser #(
    parameter int pDELAY     = 5,
    parameter int pMIN_LEN   = 64,
    parameter int pMAX_LEN   = 1518,
    parameter int pCNT_WIDTH = 16
) (
    input  logic                  i_rx_clk,
    input  logic                  i_rst,
    eth_rx_frame_parser_if.slave  rx,
    output logic [2:0]            o_fsm_state,
    output logic                  o_fsm_state_changed,
    output logic [pCNT_WIDTH-1:0] o_good_cnt,
    output logic [pCNT_WIDTH-1:0] o_bad_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_STATUS   = 3'd3,
        ST_DROP     = 3'd4
    } state_t;

    // One delay-line stage: the GMII byte plus the markers/status that
    // describe it when it leaves the line.
    typedef struct packed {
        logic        dv;
        logic        er;
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic [3:0]  err;
        logic [15:0] len;
    } stage_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] MIN_LEN     = 32'(pMIN_LEN);
    localparam logic [31:0] MAX_LEN     = 32'(pMAX_LEN);
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam int          LAST        = pDELAY - 1;
    localparam logic [pCNT_WIDTH-1:0] CNT_MAX = '1;

    // Reflected CRC-32 over one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_q;
    state_t      state_d;
    state_t      state_prev_q;
    logic        state_changed_q;

    // Strobes decoded by the FSM for the datapath
    logic        pre_load;
    logic        pre_inc;
    logic        frame_start;
    logic        data_byte;
    logic        frame_end;

    logic [2:0]  pre_cnt_q;
    logic [15:0] len_q;
    logic [31:0] crc_q;
    logic        rx_er_flag_q;
    logic [3:0]  status_err;

    stage_t      pipe_q   [pDELAY];
    stage_t      stage_in [pDELAY];

    logic [3:0]  err_hold_q;
    logic [15:0] len_hold_q;
    logic        out_ok;
    logic        out_err;

    // State register
    always_ff @(posedge i_rx_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: clocked state uses <= so every register samples the
            // pre-edge values; a blocking = here would create order-dependent
            // races between always_ff blocks.
            state_q <= state_d;
        end
    end

    // Next-state decode and datapath strobes
    always_comb begin
        // NOTE: every output of this block gets a default first; a path
        // that leaves one unassigned would infer a latch.
        state_d     = state_q;
        pre_load    = 1'b0;
        pre_inc     = 1'b0;
        frame_start = 1'b0;
        data_byte   = 1'b0;
        frame_end   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx.i_rx_dv) begin
                    if (rx.i_rx_d == PRE_BYTE) begin
                        state_d  = ST_PREAMBLE;
                        pre_load = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                // A receive error anywhere in the preamble spoils the frame,
                // even on the SFD byte itself.
                if (!rx.i_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (rx.i_rx_er) begin
                    state_d = ST_DROP;
                end else if (rx.i_rx_d == PRE_BYTE) begin
                    if (pre_cnt_q == 3'd7) begin
                        state_d = ST_DROP;
                    end else begin
                        pre_inc = 1'b1;
                    end
                end else if (rx.i_rx_d == SFD_BYTE) begin
                    state_d     = ST_DATA;
                    frame_start = 1'b1;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (rx.i_rx_dv) begin
                    data_byte = 1'b1;
                end else begin
                    state_d   = ST_STATUS;
                    frame_end = 1'b1;
                end
            end
            ST_STATUS: begin
                state_d = rx.i_rx_dv ? ST_DROP : ST_IDLE;
            end
            ST_DROP: begin
                if (!rx.i_rx_dv) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered state-change pulse; prev resets to IDLE so reset and its
    // release never produce a pulse.
    always_ff @(posedge i_rx_clk or posedge i_rst) begin
        if (i_rst) begin
            state_prev_q    <= ST_IDLE;
            state_changed_q <= 1'b0;
        end else begin
            state_prev_q    <= state_q;
            state_changed_q <= (state_q != state_prev_q);
        end
    end

    // Preamble counter, length, CRC and rx_er accumulation
    always_ff @(posedge i_rx_clk or posedge i_rst) begin
        if (i_rst) begin
            pre_cnt_q    <= 3'd0;
            len_q        <= 16'd0;
            crc_q        <= CRC_INIT;
            rx_er_flag_q <= 1'b0;
        end else begin
            if (pre_load) begin
                pre_cnt_q <= 3'd1;
            end else if (pre_inc) begin
                pre_cnt_q <= pre_cnt_q + 3'd1;
            end

            if (frame_start) begin
                len_q        <= 16'd0;
                crc_q        <= CRC_INIT;
                rx_er_flag_q <= 1'b0;
            end else if (data_byte) begin
                if (len_q != 16'hFFFF) begin
                    len_q <= len_q + 16'd1;
                end
                crc_q        <= crc32_byte(crc_q, rx.i_rx_d);
                rx_er_flag_q <= rx_er_flag_q | rx.i_rx_er;
            end
        end
    end

    // Frame status as seen in the cycle that leaves DATA
    assign status_err = {rx_er_flag_q,
                         ({16'd0, len_q} > MAX_LEN),
                         ({16'd0, len_q} < MIN_LEN),
                         (crc_q != CRC_RESIDUE)};

    // Delay-line stage inputs. The byte sampled in the last DATA cycle sits
    // in stage 0 when the frame ends, so its eof/status enter at stage 1.
    always_comb begin
        stage_in[0]     = '0;
        stage_in[0].dv  = rx.i_rx_dv;
        stage_in[0].er  = rx.i_rx_er;
        stage_in[0].d   = rx.i_rx_d;
        stage_in[0].sof = data_byte && (len_q == 16'd0);
        for (int k = 1; k < pDELAY; k++) begin
            stage_in[k] = pipe_q[k-1];
        end
        if (frame_end) begin
            stage_in[1].eof = 1'b1;
            stage_in[1].err = status_err;
            stage_in[1].len = len_q;
        end
    end

    // Delay line shift
    always_ff @(posedge i_rx_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: this shift register is reset on purpose: a reset must
            // flush any in-flight eof so no stale frame is reported.
            // Large data buffers would normally be left unreset.
            for (int k = 0; k < pDELAY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < pDELAY; k++) begin
                pipe_q[k] <= stage_in[k];
            end
        end
    end

    // Hold the last frame's status until the next eof replaces it
    always_ff @(posedge i_rx_clk or posedge i_rst) begin
        if (i_rst) begin
            err_hold_q <= 4'd0;
            len_hold_q <= 16'd0;
        end else if (pipe_q[LAST].eof) begin
            err_hold_q <= pipe_q[LAST].err;
            len_hold_q <= pipe_q[LAST].len;
        end
    end

    assign out_ok  = pipe_q[LAST].eof && (pipe_q[LAST].err == 4'd0);
    assign out_err = pipe_q[LAST].eof && (pipe_q[LAST].err != 4'd0);

    // Saturating good/bad frame counters
    always_ff @(posedge i_rx_clk or posedge i_rst) begin
        if (i_rst) begin
            o_good_cnt <= '0;
            o_bad_cnt  <= '0;
        end else begin
            if (out_ok && (o_good_cnt != CNT_MAX)) begin
                o_good_cnt <= o_good_cnt + 1'b1;
            end
            if (out_err && (o_bad_cnt != CNT_MAX)) begin
                o_bad_cnt <= o_bad_cnt + 1'b1;
            end
        end
    end

    assign rx.o_rx_dv_d   = pipe_q[LAST].dv;
    assign rx.o_rx_er_d   = pipe_q[LAST].er;
    assign rx.o_rx_d_d    = pipe_q[LAST].d;
    assign rx.o_sof       = pipe_q[LAST].sof;
    assign rx.o_eof       = pipe_q[LAST].eof;
    assign rx.o_frame_ok  = out_ok;
    assign rx.o_frame_err = out_err;
    assign rx.o_err_code  = pipe_q[LAST].eof ? pipe_q[LAST].err : err_hold_q;
    assign rx.o_frame_len = pipe_q[LAST].eof ? pipe_q[LAST].len : len_hold_q;

    assign o_fsm_state         = state_q;
    assign o_fsm_state_changed = state_changed_q;

endmodule

// File: doc/eth_rx_frame_parser.md
# eth_rx_frame_parser

Parametrised GMII receive-side frame parser, the next generation of the fixed-delay RX frame analyzer. It delineates preamble/SFD/data and passes GMII data through a configurable delay line. It checks FCS (CRC-32), frame length and `i_rx_er`, then tags the delayed stream with start/end-of-frame markers and a per-frame status. It sits directly behind the GMII receive interface and feeds downstream buffering, which uses `o_eof` plus status to commit or discard a frame.

## Interface
- `pDELAY`, 5: pipeline delay in clocks from `i_rx_*` to `o_rx_*_d`; legal range 2..32.
- `pMIN_LEN`, 64: minimum legal frame length in bytes, DA through FCS inclusive.
- `pMAX_LEN`, 1518: maximum legal frame length in bytes.
- `pCNT_WIDTH`, 16: width of the good/bad frame counters.

Ports:
- `i_rx_clk` in 1: the single clock; all logic is on its rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_rx_dv` in 1: GMII data valid.
- `i_rx_er` in 1: GMII receive error.
- `i_rx_d` in 8: GMII data.
- `o_fsm_state` out 3: current parser state.
- `o_fsm_state_changed` out 1: 1-cycle pulse when the state differs from the previous cycle.
- `o_rx_dv_d`, `o_rx_er_d` out 1 each: `i_rx_dv` / `i_rx_er` delayed by `pDELAY`.
- `o_rx_d_d` out 8: `i_rx_d` delayed by `pDELAY`.
- `o_sof` out 1: marks the delayed first byte after the SFD.
- `o_eof` out 1: marks the delayed last byte of the frame.
- `o_frame_ok` out 1: pulses with `o_eof` when `o_err_code` == 0.
- `o_frame_err` out 1: pulses with `o_eof` when `o_err_code` != 0.
- `o_err_code` out 4: bit0 CRC, bit1 runt, bit2 giant, bit3 rx_er; valid with `o_eof` and held until the next `o_eof`.
- `o_frame_len` out 16: frame byte count; valid with `o_eof` and held until the next.
- `o_good_cnt`, `o_bad_cnt` out `pCNT_WIDTH`: saturating frame counters.

## Operation
States (`o_fsm_state` encoding):
- IDLE = 0
- PREAMBLE = 1
- DATA = 2
- STATUS = 3
- DROP = 4

Transitions, evaluated on each clock with the registered state:
- **IDLE**
  - dv & d==0x55 → PREAMBLE, preamble count = 1.
  - dv & any other d → DROP.
  - !dv → stay in IDLE.
- **PREAMBLE**
  - dv & d==0x55 & count<7 → stay, count++.
  - dv & d==0x55 & count==7 → DROP.
  - dv & d==0xD5 → DATA; clear len, CRC = 0xFFFFFFFF, clear the rx_er flag.
  - dv & other d, or dv & er → DROP.
  - !dv → IDLE; no frame is reported.
- **DATA**
  - dv → stay. Each byte: len++ (saturates at 0xFFFF), CRC-32 update (reflected, poly 0xEDB88320, LSB first), rx_er flag |= er.
  - !dv → STATUS.
- **STATUS** (exactly one cycle): compute status; →IDLE if !dv, →DROP if dv.
- **DROP**: !dv → IDLE.

Status computation:
- CRC error when the CRC register != 0xDEBB20E3 (residue over data plus FCS).
- runt when len < `pMIN_LEN`.
- giant when len > `pMAX_LEN`.
- rx_er when the flag is set.

Markers:
- `o_sof` marks the first DATA byte.
- `o_eof` marks the last DATA byte.
- Zero-length frame (SFD then !dv): no `o_sof`; `o_eof` marks the delayed SFD byte with len=0, err = CRC|runt.

Counters:
- `o_good_cnt`++ on `o_frame_ok`; `o_bad_cnt`++ on `o_frame_err`.
- Both saturate at all-ones; no wrap.

Delay line:
- Passes all bytes transparently, including preamble, dropped frames and er.
- Markers are generated only for frames that reached DATA.

## Timing
- Input byte sampled at cycle t appears on `o_rx_*_d` at cycle t+`pDELAY`.
- `o_sof`, `o_eof`, `o_frame_ok`/`o_frame_err`, `o_err_code` and `o_frame_len` are cycle-aligned with the delayed byte they describe.
- Status is registered at the end of the STATUS-entry cycle, t_last+1, and is internally delayed to t_last+`pDELAY`. This requires `pDELAY` ≥ 2.
- `o_fsm_state` is the state register with no delay.
- `o_fsm_state_changed` is registered: high in the cycle after `o_fsm_state` takes a new value, for one cycle.
- Reset values: every output 0, state IDLE, delay line all-zero, counters 0, CRC 0xFFFFFFFF.
  - No `o_fsm_state_changed` pulse on reset or on reset release.
- Reset asserted mid-frame clears everything immediately, with no `o_eof` and no counter update. The first frame whose preamble starts after release parses normally.
- Back-to-back frames: a new preamble may start the cycle after STATUS. A frame whose status is still in flight in the delay line is unaffected by the next frame's start.

## Test plan
- **Good 64-byte frame** (`pDELAY`=5): 7×0x55, 0xD5, 60 payload bytes, correct FCS.
  - State sequence 0→1→2→3→0.
  - `o_sof` 5 cycles after the first payload byte; `o_eof` on the delayed last FCS byte.
  - `o_frame_ok`=1, len=64, err=0, `o_good_cnt`=1.
- **Corrupt payload**: same frame with one payload bit flipped → `o_frame_err`=1, err=4'b0001, len=64, `o_bad_cnt`=1.
- **Length limits**
  - 40-byte frame with valid FCS → err=4'b0010.
  - 1600-byte frame with valid FCS → err=4'b0100, len=1600.
  - 0xFFFF-byte stream → len saturates at 0xFFFF.
- **Error and bad preamble**
  - `i_rx_er`=1 on payload byte 20 → err bit3 set, frame_err.
  - Preamble byte 0x5A → state 4, no `o_sof`/`o_eof`, counters unchanged, delayed data still passes through.
  - 8×0x55 before the SFD → DROP.
- **Reset mid-frame**: assert `i_rst` mid-DATA → outputs 0 immediately, no `o_eof`. A following good frame gives `o_good_cnt`=1.
- **Back-to-back**: two good frames with a 12-cycle IFG → two `o_eof`/`o_frame_ok` pulses, `o_good_cnt`=2. Exactly 4 `o_fsm_state_changed` pulses per frame.
